// File: rtl/flash_cmd_seq.sv
// Command sequencer for a byte-wide parallel flash behind a simple bus bridge.
// Expands read/program/erase/status requests into bridge write/read cycles, with status polling.
`timescale 1ns/1ps
module flash_cmd_seq #(
    parameter int unsigned POLL_MAX = 50000
) (
    input  logic       CLK_50MHZ,
    input  logic       RST,
    input  logic       op_start,
    input  logic [1:0] op,
    input  logic [7:0] op_addr,
    input  logic [7:0] op_wdata,
    output logic [7:0] op_rdata,
    output logic       op_busy,
    output logic       op_done,
    output logic       op_error,
    output logic [7:0] addr,
    inout  wire  [7:0] data,
    output logic       direction_rw,
    output logic       fb_start,
    input  logic       fb_done
);

    localparam int unsigned CNT_W = 16;

    localparam logic [2:0] STEP_CMD  = 3'd0;
    localparam logic [2:0] STEP_ARG  = 3'd1;
    localparam logic [2:0] STEP_POLL = 3'd2;
    localparam logic [2:0] STEP_CLR  = 3'd3;
    localparam logic [2:0] STEP_RA   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        EVAL   = 3'd3,
        FINISH = 3'd4
    } state_t;

    state_t             state;
    logic [2:0]         step;
    logic [1:0]         op_q;
    logic [7:0]         wdata_q;
    logic [7:0]         wr_byte;
    logic               data_oe;
    logic [7:0]         rd_q;
    logic [CNT_W-1:0]   poll_cnt;
    logic [7:0]         res_data;
    logic               res_err;

    logic               is_read_op_c;
    logic               poll_end_c;
    logic               last_step_c;
    logic [2:0]         next_step_c;
    logic [8:0]         cyc_first_c;
    logic [8:0]         cyc_next_c;

    // Bus cycle for a given step: {is_read, write byte}.
    function automatic logic [8:0] bus_cycle(input logic [1:0] o, input logic [2:0] s,
                                             input logic [7:0] wd);
        bus_cycle = {1'b0, 8'hFF};
        case (s)
            STEP_CMD: begin
                case (o)
                    2'b00:   bus_cycle = {1'b0, 8'hFF};
                    2'b01:   bus_cycle = {1'b0, 8'h40};
                    2'b10:   bus_cycle = {1'b0, 8'h20};
                    default: bus_cycle = {1'b0, 8'h70};
                endcase
            end
            STEP_ARG: begin
                case (o)
                    2'b01:   bus_cycle = {1'b0, wd};
                    2'b10:   bus_cycle = {1'b0, 8'hD0};
                    default: bus_cycle = {1'b1, 8'h00};
                endcase
            end
            STEP_POLL: bus_cycle = {1'b1, 8'h00};
            STEP_CLR:  bus_cycle = {1'b0, 8'h50};
            default:   bus_cycle = {1'b0, 8'hFF};
        endcase
    endfunction

    assign is_read_op_c = (op_q == 2'b00) || (op_q == 2'b11);
    assign poll_end_c   = rd_q[7] || (poll_cnt >= CNT_W'(POLL_MAX));

    // Step sequencing decided in EVAL.
    always_comb begin
        next_step_c = step;
        last_step_c = 1'b0;
        case (step)
            STEP_CMD:  next_step_c = STEP_ARG;
            STEP_ARG: begin
                if (is_read_op_c) last_step_c = 1'b1;
                else              next_step_c = STEP_POLL;
            end
            STEP_POLL: next_step_c = poll_end_c ? STEP_CLR : STEP_POLL;
            STEP_CLR:  next_step_c = STEP_RA;
            default:   last_step_c = 1'b1;
        endcase
    end

    assign cyc_first_c = bus_cycle(op, STEP_CMD, op_wdata);
    assign cyc_next_c  = bus_cycle(op_q, next_step_c, wdata_q);

    assign data = data_oe ? wr_byte : 'z;

    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            step         <= STEP_CMD;
            op_q         <= 2'b00;
            wdata_q      <= 8'h00;
            wr_byte      <= 8'h00;
            data_oe      <= 1'b0;
            rd_q         <= 8'h00;
            poll_cnt     <= '0;
            res_data     <= 8'h00;
            res_err      <= 1'b0;
            op_rdata     <= 8'h00;
            op_busy      <= 1'b0;
            op_done      <= 1'b0;
            op_error     <= 1'b0;
            addr         <= 8'h00;
            direction_rw <= 1'b1;
            fb_start     <= 1'b0;
        end else begin
            op_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_start) begin
                        op_q         <= op;
                        addr         <= op_addr;
                        wdata_q      <= op_wdata;
                        step         <= STEP_CMD;
                        poll_cnt     <= '0;
                        op_busy      <= 1'b1;
                        direction_rw <= cyc_first_c[8];
                        wr_byte      <= cyc_first_c[7:0];
                        data_oe      <= ~cyc_first_c[8];
                        fb_start     <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (fb_done) begin
                        fb_start <= 1'b0;
                        data_oe  <= 1'b0;
                        if (direction_rw) rd_q <= data;
                        if (step == STEP_POLL) poll_cnt <= poll_cnt + CNT_W'(1);
                        state <= EVAL;
                    end
                end
                EVAL: begin
                    // Poll ends on ready or timeout; timeout always reports an error.
                    if (step == STEP_POLL && poll_end_c) begin
                        res_data <= rd_q;
                        res_err  <= ~rd_q[7] | rd_q[5] | rd_q[4] | rd_q[3] | rd_q[1];
                    end
                    if (last_step_c) begin
                        op_rdata     <= is_read_op_c ? rd_q : res_data;
                        op_error     <= is_read_op_c ? 1'b0 : res_err;
                        op_done      <= 1'b1;
                        direction_rw <= 1'b1;
                        state        <= FINISH;
                    end else begin
                        step         <= next_step_c;
                        direction_rw <= cyc_next_c[8];
                        wr_byte      <= cyc_next_c[7:0];
                        data_oe      <= ~cyc_next_c[8];
                        fb_start     <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                FINISH: begin
                    op_busy <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_cmd_seq.sv
// Bench for flash_cmd_seq: bridge model with a bus-cycle scoreboard and table-driven operations.
`timescale 1ns/1ps
module tb_flash_cmd_seq;

    localparam int unsigned POLL_MAX = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       op_start;
    logic [1:0] op;
    logic [7:0] op_addr;
    logic [7:0] op_wdata;
    logic [7:0] op_rdata;
    logic       op_busy;
    logic       op_done;
    logic       op_error;
    logic [7:0] addr;
    wire  [7:0] data;
    logic       direction_rw;
    logic       fb_start;
    logic       fb_done;

    logic [7:0] br_rd;
    logic       br_drv;

    assign data = (br_drv && direction_rw) ? br_rd : 'z;

    flash_cmd_seq #(.POLL_MAX(POLL_MAX)) dut (
        .CLK_50MHZ   (clk),
        .RST         (rst),
        .op_start    (op_start),
        .op          (op),
        .op_addr     (op_addr),
        .op_wdata    (op_wdata),
        .op_rdata    (op_rdata),
        .op_busy     (op_busy),
        .op_done     (op_done),
        .op_error    (op_error),
        .addr        (addr),
        .data        (data),
        .direction_rw(direction_rw),
        .fb_start    (fb_start),
        .fb_done     (fb_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       dir;
        logic [7:0] a;
        logic [7:0] d;
    } cyc_t;

    typedef struct {
        logic [1:0]      op;
        logic [7:0]      a;
        logic [7:0]      wd;
        logic [2:0][7:0] st;
        int              ns;
        logic [7:0]      rdata;
        logic            err;
    } vec_t;

    cyc_t       exp_cyc[$];
    logic [8:0] exp_res[$];
    logic [7:0] stat_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         done_cnt = 0;
    int         cyc_seen = 0;
    vec_t       vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Bridge model: each request takes three cycles to fb_done; every cycle is scored.
    initial begin : bridge
        bit   active;
        int   wait_cnt;
        cyc_t got;
        cyc_t want;
        active = 0;
        wait_cnt = 0;
        br_drv = 1'b0;
        br_rd = 8'h00;
        fb_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 0;
                fb_done = 1'b0;
                br_drv = 1'b0;
            end else if (fb_done) begin
                fb_done = 1'b0;
                br_drv = 1'b0;
                active = 0;
                check("fb_start_drop", 32'(fb_start), 32'd0);
            end else if (active) begin
                check("fb_start_hold", 32'(fb_start), 32'd1);
                if (direction_rw) check("rd_bus_value", 32'(data), 32'(br_rd));
                wait_cnt--;
                if (wait_cnt == 0) fb_done = 1'b1;
            end else if (fb_start) begin
                active = 1;
                wait_cnt = 2;
                cyc_seen++;
                got = '{dir: direction_rw, a: addr, d: (direction_rw ? 8'h00 : data)};
                if (direction_rw) begin
                    br_rd = (stat_q.size() != 0) ? stat_q.pop_front() : 8'h00;
                    br_drv = 1'b1;
                end
                if (exp_cyc.size() == 0) begin
                    fail_now("bus_cycle_unexpected");
                end else begin
                    want = exp_cyc.pop_front();
                    check("bus_cycle", 32'(got), 32'(want));
                end
            end
        end
    end

    // Result scoreboard: one expected {error, rdata} per op_done.
    initial begin : done_mon
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (op_done === 1'b1) begin
                done_cnt++;
                if (exp_res.size() == 0) begin
                    fail_now("op_done_unexpected");
                end else begin
                    e = exp_res.pop_front();
                    check("op_rdata", 32'(op_rdata), 32'(e[7:0]));
                    check("op_error", 32'(op_error), 32'(e[8]));
                end
            end
        end
    end

    task automatic push_w(input logic [7:0] a, input logic [7:0] d);
        exp_cyc.push_back('{dir: 1'b0, a: a, d: d});
    endtask

    task automatic push_r(input logic [7:0] a);
        exp_cyc.push_back('{dir: 1'b1, a: a, d: 8'h00});
    endtask

    // Reference sequence for one operation, with the status values the bridge will return.
    task automatic push_expect(input vec_t v);
        int         cnt;
        logic [7:0] s;
        for (int i = 0; i < v.ns; i++) stat_q.push_back(v.st[i]);
        exp_res.push_back({v.err, v.rdata});
        case (v.op)
            2'b00: begin push_w(v.a, 8'hFF); push_r(v.a); end
            2'b11: begin push_w(v.a, 8'h70); push_r(v.a); end
            default: begin
                if (v.op == 2'b01) begin push_w(v.a, 8'h40); push_w(v.a, v.wd); end
                else               begin push_w(v.a, 8'h20); push_w(v.a, 8'hD0); end
                cnt = 0;
                do begin
                    push_r(v.a);
                    s = (cnt < v.ns) ? v.st[cnt] : 8'h00;
                    cnt++;
                end while (!s[7] && cnt < int'(POLL_MAX));
                push_w(v.a, 8'h50);
                push_w(v.a, 8'hFF);
            end
        endcase
    endtask

    task automatic run_op(input vec_t v, input bit poke_busy, input bit poke_finish);
        int d0;
        int i;
        for (i = 0; i < 50 && op_busy !== 1'b0; i++) @(negedge clk);
        if (op_busy !== 1'b0) fail_now("idle_wait_timeout");
        push_expect(v);
        d0 = done_cnt;
        op = v.op;
        op_addr = v.a;
        op_wdata = v.wd;
        op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        check("busy_after_accept", 32'(op_busy), 32'd1);
        if (poke_busy) begin
            @(negedge clk);
            op = 2'b10;
            op_addr = 8'hEE;
            op_start = 1'b1;
            @(negedge clk);
            op_start = 1'b0;
        end
        for (i = 0; i < 300 && op_done !== 1'b1; i++) @(negedge clk);
        if (op_done !== 1'b1) begin
            fail_now("op_done_timeout");
        end else if (poke_finish) begin
            op = 2'b00;
            op_addr = 8'h44;
            op_start = 1'b1;
            @(negedge clk);
            op_start = 1'b0;
            for (int k = 0; k < 5; k++) begin
                check("no_start_after_finish", 32'(fb_start), 32'd0);
                @(negedge clk);
            end
        end else begin
            @(negedge clk);
        end
        @(negedge clk);
        check("busy_after_done", 32'(op_busy), 32'd0);
        check("cycles_left", 32'(exp_cyc.size()), 32'd0);
        check("done_count", 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin : watchdog
        #1000000;
        fail_now("watchdog");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int   seen0;
        vec_t rv;
        rst = 1'b1;
        op_start = 1'b0;
        op = 2'b00;
        op_addr = 8'h00;
        op_wdata = 8'h00;

        vecs[0] = '{2'b00, 8'h12, 8'h00, {8'h00, 8'h00, 8'hA5}, 1, 8'hA5, 1'b0};
        vecs[1] = '{2'b01, 8'h34, 8'h3C, {8'h80, 8'h00, 8'h00}, 3, 8'h80, 1'b0};
        vecs[2] = '{2'b10, 8'h56, 8'h00, {8'h00, 8'h00, 8'hA0}, 1, 8'hA0, 1'b1};
        vecs[3] = '{2'b01, 8'h78, 8'h11, {8'h00, 8'h00, 8'h00}, 0, 8'h00, 1'b1};
        vecs[4] = '{2'b11, 8'h9A, 8'h00, {8'h00, 8'h00, 8'hC4}, 1, 8'hC4, 1'b0};
        vecs[5] = '{2'b10, 8'hBC, 8'h00, {8'h00, 8'h82, 8'h00}, 2, 8'h82, 1'b1};
        vecs[6] = '{2'b01, 8'hDE, 8'h5A, {8'h00, 8'h00, 8'h88}, 1, 8'h88, 1'b1};
        vecs[7] = '{2'b01, 8'h01, 8'hC3, {8'h00, 8'h00, 8'h80}, 1, 8'h80, 1'b0};
        vecs[8] = '{2'b00, 8'hFF, 8'h00, {8'h00, 8'h00, 8'h00}, 1, 8'h00, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_fb_start", 32'(fb_start), 32'd0);
        check("rst_dir", 32'(direction_rw), 32'd1);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_busy", 32'(op_busy), 32'd0);
        check("rst_done", 32'(op_done), 32'd0);
        check("rst_error", 32'(op_error), 32'd0);
        check("rst_rdata", 32'(op_rdata), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) run_op(vecs[i], 1'b0, 1'b0);

        // op_start while busy must not disturb a read.
        rv = '{2'b00, 8'h21, 8'h00, {8'h00, 8'h00, 8'h5E}, 1, 8'h5E, 1'b0};
        run_op(rv, 1'b1, 1'b0);

        // op_start coincident with FINISH must be ignored.
        rv = '{2'b11, 8'h22, 8'h00, {8'h00, 8'h00, 8'h90}, 1, 8'h90, 1'b0};
        run_op(rv, 1'b0, 1'b1);
        check("rdata_held", 32'(op_rdata), 32'h90);

        // Reset during WAIT of a program abandons the sequence.
        rv = '{2'b01, 8'h66, 8'h77, {8'h00, 8'h00, 8'h80}, 1, 8'h80, 1'b0};
        push_expect(rv);
        op = rv.op;
        op_addr = rv.a;
        op_wdata = rv.wd;
        op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        for (int i = 0; i < 20 && fb_start !== 1'b1; i++) @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_fb_start", 32'(fb_start), 32'd0);
        check("midrst_busy", 32'(op_busy), 32'd0);
        check("midrst_dir", 32'(direction_rw), 32'd1);
        check("midrst_addr", 32'(addr), 32'd0);
        check("midrst_done", 32'(op_done), 32'd0);
        check("midrst_error", 32'(op_error), 32'd0);
        check("midrst_rdata", 32'(op_rdata), 32'd0);
        exp_cyc.delete();
        exp_res.delete();
        stat_q.delete();
        seen0 = cyc_seen;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (fb_start !== 1'b0) fail_now("fb_start_after_rst");
        end
        check("no_cycles_after_rst", 32'(cyc_seen - seen0), 32'd0);

        rv = '{2'b00, 8'h33, 8'h00, {8'h00, 8'h00, 8'h6B}, 1, 8'h6B, 1'b0};
        run_op(rv, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/flash_cmd_seq.md
FLASH_CMD_SEQ -- requirements
Module: flash_cmd_seq

Interface
REQ-001 SHALL have parameter POLL_MAX, default 50000, giving the maximum number of status reads per program or erase before a timeout.
REQ-002 SHALL have port CLK_50MHZ, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port op_start, input, 1 bit: single-cycle request pulse from the client.
REQ-005 SHALL have port op, input, 2 bits: 00 read byte, 01 program byte, 10 erase block, 11 read status.
REQ-006 SHALL have port op_addr, input, 8 bits: target address.
REQ-007 SHALL have port op_wdata, input, 8 bits: byte to program.
REQ-008 SHALL have port op_rdata, output, 8 bits: byte read (op 00) or final status register (other ops).
REQ-009 SHALL have port op_busy, output, 1 bit: high from the cycle after an accepted op_start until op_done.
REQ-010 SHALL have port op_done, output, 1 bit: single-cycle completion pulse.
REQ-011 SHALL have port op_error, output, 1 bit: valid with op_done.
REQ-012 SHALL have port addr, output, 8 bits: bridge address.
REQ-013 SHALL have port data, inout, 8 bits: bridge data bus.
REQ-014 SHALL have port direction_rw, output, 1 bit: 1 = read, 0 = write.
REQ-015 SHALL have port fb_start, output, 1 bit: bridge request.
REQ-016 SHALL have port fb_done, input, 1 bit: bridge completion pulse.

Function
REQ-017 SHALL accept op_start only in state IDLE and ignore it while op_busy is high; op, op_addr and op_wdata SHALL be latched on acceptance.
REQ-018 SHALL use the states IDLE, ISSUE, WAIT, EVAL and FINISH: IDLE->ISSUE on accept; ISSUE->WAIT after one cycle; WAIT->EVAL on fb_done; EVAL->ISSUE (next step or poll) or FINISH; FINISH->IDLE after one cycle.
REQ-019 SHALL raise fb_start in ISSUE and hold it until the edge on which fb_done is sampled high, deasserting it registered on that edge.
REQ-020 SHALL hold addr, direction_rw and the driven data byte stable from ISSUE through WAIT.
REQ-021 SHALL drive data only while direction_rw=0 and the state is ISSUE or WAIT, and SHALL be high-Z otherwise.
REQ-022 SHALL capture data on the cycle fb_done=1 when direction_rw=1.
REQ-023 SHALL use the latched op_addr as addr for every bus cycle of an operation.
REQ-024 SHALL issue read byte as: write 0xFF, then read; op_rdata = read byte; op_error = 0.
REQ-025 SHALL issue read status as: write 0x70, then read; op_rdata = status; op_error = 0.
REQ-026 SHALL issue program as: write 0x40, write op_wdata, then poll.
REQ-027 SHALL issue erase as: write 0x20, write 0xD0, then poll.
REQ-028 Poll SHALL be repeated reads until status bit 7 = 1, using a 16-bit counter that counts reads.
REQ-029 If the poll counter reaches POLL_MAX with status bit 7 still 0, polling SHALL stop and op_error SHALL be 1.
REQ-030 After a poll ends (ready or timeout), SHALL write 0x50 (clear status) then 0xFF (read array) before FINISH.
REQ-031 For program/erase, op_rdata SHALL be the last polled status, and op_error = SR5|SR4|SR3|SR1|timeout.
REQ-032 SHALL pulse op_done for one cycle in FINISH; op_rdata and op_error SHALL hold until the next accepted op.
REQ-033 op_start coincident with FINISH SHALL be ignored; it is accepted only from IDLE.

Reset
REQ-034 On RST=1, asynchronously and regardless of state, SHALL force: state IDLE, fb_start=0, direction_rw=1, data high-Z, addr=0, op_busy=0, op_done=0, op_error=0, op_rdata=0, poll counter=0.
REQ-035 Reset mid-operation SHALL abandon the sequence without issuing the clear-status or read-array cycles.

Verification
- Read: op=00, op_addr=0x12, bridge model returns 0xA5 -> bus cycles W 0xFF@0x12, R@0x12; op_rdata=0xA5, op_error=0, exactly one op_done.
- Program: op=01, op_wdata=0x3C, status 0x00,0x00,0x80 -> W40, W3C, R, R, R, W50, WFF; op_rdata=0x80, op_error=0.
- Erase error: op=10, status 0xA0 -> W20, WD0, R, W50, WFF; op_error=1, op_rdata=0xA0.
- Timeout: POLL_MAX=4, status stuck 0x00 -> exactly 4 poll reads, then W50, WFF; op_error=1.
- Handshake: op_start pulsed while busy ignored; fb_start drops on the fb_done edge; data high-Z during every read cycle.
- RST asserted during WAIT of a program -> outputs at reset values immediately, no further fb_start; a new read completes correctly afterwards.
